// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front end for the RGB sequencer's button input. It takes a raw, bouncing,
// asynchronous push-button and produces a clean debounced level plus
// single-cycle event pulses: press, release, long-press and auto-repeat.
// press_pulse feeds the sequencer's button input directly, so each physical
// press advances the colour sequence exactly once.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   button_raw     raw push-button, asynchronous to clk, may bounce
//   level          debounced button level
//   press_pulse    one cycle, debounced rising edge
//   release_pulse  one cycle, debounced falling edge
//   long_pulse     one cycle, press has lasted HOLD_CYCLES
//   repeat_pulse   one cycle, every REPEAT_CYCLES while long-pressed
//
// All outputs are registered; there is no combinational path from button_raw.
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int HOLD_CYCLES     = 50000,
   parameter int REPEAT_CYCLES   = 10000
) (
   input  logic clk,
   input  logic reset,
   input  logic button_raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PRESSED = 2'd1;
   localparam logic [1:0] HELD    = 2'd2;

   // --------------------------------------------------------------------------
   // Synchronizer: plain shift chain, last stage is the only one used.
   // --------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // --------------------------------------------------------------------------
   // Debounce: the level only flips after s has disagreed with it on
   // DEBOUNCE_CYCLES consecutive edges. A single agreeing cycle restarts the
   // count, which rejects glitches shorter than the debounce window.
   // --------------------------------------------------------------------------
   logic [DB_W-1:0] db_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level  <= 1'b0;
         db_cnt <= '0;
      end else if (s == level) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         level  <= s;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   // --------------------------------------------------------------------------
   // Edge detect. level_d is cleared with level, so reset release never looks
   // like an edge. rise/fall are also the FSM's event inputs, which makes the
   // FSM react on the same edge the pulses are registered.
   // --------------------------------------------------------------------------
   logic level_d;
   logic rise;
   logic fall;

   assign rise = level & ~level_d;
   assign fall = ~level & level_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_d       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         level_d       <= level;
         press_pulse   <= rise;
         release_pulse <= fall;
      end
   end

   // --------------------------------------------------------------------------
   // Hold / repeat FSM.
   //   IDLE    -> PRESSED on rise, hold counter cleared.
   //   PRESSED counts up to HOLD_CYCLES-1, then long_pulse and -> HELD.
   //   HELD    fires repeat_pulse every REPEAT_CYCLES.
   // A fall is checked first so a release always beats a long/repeat event
   // due on the same edge. Counters saturate at their terminal value by
   // construction (they are cleared or the state changes there).
   // --------------------------------------------------------------------------
   logic [1:0]        state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [REP_W-1:0]  rep_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         hold_cnt     <= '0;
         rep_cnt      <= '0;
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
      end else begin
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
         if (fall) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (rise) begin
                     state    <= PRESSED;
                     hold_cnt <= '0;
                  end
               end
               PRESSED: begin
                  if (hold_cnt == HOLD_LAST) begin
                     state      <= HELD;
                     long_pulse <= 1'b1;
                     hold_cnt   <= '0;
                     rep_cnt    <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
               HELD: begin
                  if (rep_cnt == REP_LAST) begin
                     repeat_pulse <= 1'b1;
                     rep_cnt      <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + REP_W'(1);
                  end
               end
               default: begin
                  state    <= IDLE;
                  hold_cnt <= '0;
                  rep_cnt  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Bench for button_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=10, REPEAT_CYCLES=3. Every cycle the DUT outputs are compared
// with an event-level reference model (sample history queue, disagreement
// run length, elapsed time since press). A hand-derived vector table covers
// a clean press/release, and scripted sequences cover bounce, glitches,
// long press with repeat, release racing long press, and reset mid-hold.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int SYNC = 2;
   localparam int DC   = 4;
   localparam int HOLD = 10;
   localparam int REP  = 3;

   logic clk = 1'b0;
   logic reset;
   logic button_raw;
   logic level, press_pulse, release_pulse, long_pulse, repeat_pulse;

   always #5 clk = ~clk;

   button_conditioner #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC),
      .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk), .reset(reset), .button_raw(button_raw),
      .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   bit rawq[$];
   bit m_s, m_level, m_level_d, m_pressed;
   int m_run, m_t0;
   logic [4:0] m_exp;   // {level, press, release, long, repeat}

   // observed pulse bookkeeping
   int n_press, n_rel, n_long, n_rep;
   int press_at, rel_at, long_at, first_rep_at, last_rep_at;

   typedef struct {
      bit         raw;
      logic [4:0] exp;
   } vec_t;
   vec_t tbl[17];

   function automatic logic [4:0] outs();
      return {level, press_pulse, release_pulse, long_pulse, repeat_pulse};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      rawq.delete();
      m_s = 0; m_level = 0; m_level_d = 0; m_pressed = 0;
      m_run = 0; m_t0 = 0; m_exp = '0;
   endtask

   // One clock edge of the reference behaviour, stated in terms of events:
   // level flips after DC consecutive disagreeing samples; pulses follow a
   // level change by one edge; long fires HOLD edges after the press pulse,
   // repeats every REP edges after that; a release cancels everything.
   task automatic model_step(input bit raw);
      bit rise, fall, old_level, lp, rp;
      int el;
      rise = m_level && !m_level_d;
      fall = !m_level && m_level_d;
      lp = 0; rp = 0;
      if (fall) m_pressed = 0;
      else if (m_pressed) begin
         el = cyc - m_t0;
         lp = (el == HOLD);
         rp = (el > HOLD) && ((el - HOLD) % REP == 0);
      end else if (rise) begin
         m_pressed = 1;
         m_t0 = cyc;
      end
      old_level = m_level;
      if (m_s != m_level) begin
         m_run++;
         if (m_run == DC) begin
            m_level = m_s;
            m_run = 0;
         end
      end else m_run = 0;
      m_level_d = old_level;
      rawq.push_back(raw);
      if (rawq.size() > SYNC) void'(rawq.pop_front());
      m_s = (rawq.size() == SYNC) ? rawq[0] : 1'b0;
      m_exp = {m_level, rise, fall, lp, rp};
   endtask

   task automatic clear_counts();
      n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
      press_at = -1; rel_at = -1; long_at = -1; first_rep_at = -1; last_rep_at = -1;
   endtask

   // Called at a negedge: drive raw, step one edge, compare at the next negedge.
   task automatic tick(input bit v);
      button_raw = v;
      @(posedge clk);
      cyc++;
      model_step(v);
      @(negedge clk);
      chk($sformatf("model_out c%0d", cyc), int'(outs()), int'(m_exp));
      if (press_pulse)   begin n_press++; press_at = cyc; end
      if (release_pulse) begin n_rel++;   rel_at   = cyc; end
      if (long_pulse)    begin n_long++;  long_at  = cyc; end
      if (repeat_pulse) begin
         n_rep++;
         if (first_rep_at < 0) first_rep_at = cyc;
         last_rep_at = cyc;
      end
   endtask

   // Asserted mid-cycle to show the clear is asynchronous.
   task automatic do_reset();
      #3 reset = 1'b1;
      #1 chk("reset_async_outs", int'(outs()), 0);
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_held_outs", int'(outs()), 0);
      reset = 1'b0;
   endtask

   initial begin
      int e1;
      reset = 1'b1;
      button_raw = 1'b0;
      model_reset();
      clear_counts();
      repeat (3) @(negedge clk);
      chk("reset_state", int'(outs()), 0);
      reset = 1'b0;
      repeat (5) tick(1'b0);

      // ---- clean press and release, hand-derived table ----
      for (int i = 0; i < 17; i++) tbl[i] = '{raw: (i < 9), exp: 5'b00000};
      for (int i = 7; i <= 13; i++) tbl[i].exp = 5'b10000;
      tbl[5].exp  = 5'b10000;   // edge 6: level rises
      tbl[6].exp  = 5'b11000;   // edge 7: press pulse
      tbl[15].exp = 5'b00100;   // edge 16: release pulse
      for (int i = 0; i < 17; i++) begin
         tick(tbl[i].raw);
         chk($sformatf("table_row%0d", i), int'(outs()), int'(tbl[i].exp));
      end
      repeat (4) tick(1'b0);

      // ---- bounce ----
      clear_counts();
      tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
      e1 = cyc + 1;
      repeat (9) tick(1'b1);
      chk("bounce_press_count", n_press, 1);
      chk("bounce_press_lat", press_at - e1 + 1, 7);
      repeat (10) tick(1'b0);
      chk("bounce_rel_count", n_rel, 1);
      chk("bounce_no_long", n_long, 0);

      // ---- glitches: one-cycle highs every 3 cycles ----
      clear_counts();
      for (int i = 0; i < 50; i++) tick(i % 3 == 0);
      repeat (3) tick(1'b0);
      chk("glitch_press", n_press, 0);
      chk("glitch_rel", n_rel, 0);
      chk("glitch_level", int'(level), 0);

      // ---- long press with repeat ----
      clear_counts();
      e1 = cyc + 1;
      repeat (40) tick(1'b1);
      repeat (12) tick(1'b0);
      chk("long_press_lat", press_at - e1 + 1, 7);
      chk("long_count", n_long, 1);
      chk("long_after_press", long_at - press_at, HOLD);
      chk("first_repeat_gap", first_rep_at - long_at, REP);
      chk("repeat_count", n_rep, 9);
      chk("rel_lat", rel_at - e1 + 1, 47);
      chk("no_repeat_after_rel", int'(last_rep_at < rel_at), 1);
      chk("long_rel_count", n_rel, 1);

      // ---- release racing long: release pulse lands on the long edge ----
      clear_counts();
      e1 = cyc + 1;
      repeat (10) tick(1'b1);
      repeat (25) tick(1'b0);
      chk("race_rel_edge", rel_at - e1 + 1, 17);
      chk("race_rel_count", n_rel, 1);
      chk("race_no_long", n_long, 0);
      chk("race_no_repeat", n_rep, 0);

      // ---- reset while held in long-press ----
      clear_counts();
      repeat (25) tick(1'b1);
      chk("pre_reset_long", n_long, 1);
      chk("pre_reset_level", int'(level), 1);
      do_reset();
      clear_counts();
      e1 = cyc + 1;
      repeat (20) tick(1'b1);
      chk("post_reset_press_lat", press_at - e1 + 1, 7);
      chk("post_reset_long", long_at - press_at, HOLD);
      repeat (10) tick(1'b0);

      // ---- randomized runs against the model ----
      for (int k = 0; k < 80; k++) begin
         bit v;
         int len;
         v = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 45))
                                           : int'($urandom_range(1, 3));
         repeat (len) tick(v);
         if (k == 40) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
